// File: rtl/fetch_pred_reg.sv
// -----------------------------------------------------------------------------
// fetch_pred_reg
//   Fetch-side F pipeline register for the Y86-64 pipeline. Holds the
//   predicted PC, computes the next prediction from the instruction fetched
//   this cycle (always-taken for jXX/call), honours the F-stage stall and
//   latches a fetch-stop state on halt / invalid icode / imem error. A stop
//   is cancelled by a mispredicted branch in M or a ret reaching W.
//
//   Optional feature macro: FETCH_PERF_EN (builds the saturating
//   performance counters; when undefined the perf outputs are tied to 0).
//
// Ports
//   clk_i            pipeline clock, rising edge
//   rst_i            synchronous active-high reset
//   f_icode_i        icode of the instruction fetched this cycle
//   f_valc_i         constant word of the fetched instruction
//   f_valp_i         address of the next sequential instruction
//   imem_error_i     fetch address out of range
//   f_stall_i        hold the F register
//   m_icode_i        icode in M stage
//   m_cnd_i          condition result in M stage
//   w_icode_i        icode in W stage
//   f_predpc_o       registered predicted PC
//   f_stop_o         registered fetch-stopped flag
//   perf_fetch_cnt_o instructions accepted
//   perf_stall_cnt_o stalled cycles
// -----------------------------------------------------------------------------
module fetch_pred_reg #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  f_icode_i,
  input  logic [63:0] f_valc_i,
  input  logic [63:0] f_valp_i,
  input  logic        imem_error_i,
  input  logic        f_stall_i,
  input  logic [3:0]  m_icode_i,
  input  logic        m_cnd_i,
  input  logic [3:0]  w_icode_i,
  output logic [63:0] f_predpc_o,
  output logic        f_stop_o,
  output logic [31:0] perf_fetch_cnt_o,
  output logic [31:0] perf_stall_cnt_o
);

  localparam logic [3:0] I_HALT = 4'h0;
  localparam logic [3:0] I_JXX  = 4'h7;
  localparam logic [3:0] I_CALL = 4'h8;
  localparam logic [3:0] I_RET  = 4'h9;
  localparam logic [3:0] I_MAX  = 4'hB;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_STOP = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] pred_s;
  logic        redirect_s;
  logic        stop_ev_s;

  // Prediction, redirect decode and stop-event detection.
  always_comb begin
    pred_s     = f_valp_i;
    redirect_s = 1'b0;
    stop_ev_s  = 1'b0;
    if ((f_icode_i == I_JXX) || (f_icode_i == I_CALL)) begin
      pred_s = f_valc_i;
    end else begin
      pred_s = f_valp_i;
    end
    redirect_s = ((m_icode_i == I_JXX) && !m_cnd_i) || (w_icode_i == I_RET);
    // A redirect squashes whatever was fetched this cycle, so it cannot stop.
    stop_ev_s  = !redirect_s &&
                 ((f_icode_i == I_HALT) || (f_icode_i > I_MAX) || imem_error_i);
  end

  // Next-state and next-PC: redirect beats stall, stall beats normal update.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (redirect_s) begin
      pc_d    = pred_s;
      state_d = ST_RUN;
    end else if (f_stall_i) begin
      pc_d    = pc_q;
      state_d = state_q;
    end else begin
      case (state_q)
        ST_RUN: begin
          pc_d    = pred_s;
          state_d = stop_ev_s ? ST_STOP : ST_RUN;
        end
        ST_STOP: begin
          pc_d    = pc_q;
          state_d = ST_STOP;
        end
        default: begin
          pc_d    = pc_q;
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // F register and fetch state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q    <= RESET_PC;
      state_q <= ST_RUN;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  assign f_predpc_o = pc_q;
  assign f_stop_o   = (state_q == ST_STOP);

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating counter increments.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if ((state_q == ST_RUN) && !f_stall_i && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end else begin
      fetch_cnt_d = fetch_cnt_q;
    end
    if (f_stall_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Counter registers, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_fetch_cnt_o = fetch_cnt_q;
  assign perf_stall_cnt_o = stall_cnt_q;
`else
  assign perf_fetch_cnt_o = 32'd0;
  assign perf_stall_cnt_o = 32'd0;
`endif

endmodule

// File: doc/fetch_pred_reg.md
# fetch_pred_reg

Fetch-side producer of the predicted PC consumed by the PC selection logic in the Y86-64 pipeline. Holds the F pipeline register (`F_predPC`), computes the next predicted PC from the instruction just fetched, honours the F-stage stall, and latches a fetch-stop state on `halt`, an invalid instruction or an imem error. A stop is cancelled when a branch mispredict or a `ret` redirect arrives from M/W.

## Interface
- `RESET_PC`, default `64'h0`: value loaded into `F_predPC` on reset.
- `clk`  in  1: pipeline clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `f_icode`  in  4: icode of the instruction fetched this cycle.
- `f_valC`  in  64: constant word of the fetched instruction.
- `f_valP`  in  64: address of the next sequential instruction.
- `imem_error`  in  1: the fetch address this cycle is out of range.
- `F_stall`  in  1: hold the F register (from pipeline control).
- `M_icode`  in  4: icode in M stage.
- `M_cnd`  in  1: condition result in M stage.
- `W_icode`  in  4: icode in W stage.
- `F_predPC`  out  64: registered predicted PC.
- `F_stop`  out  1: registered; fetch is stopped and `F_predPC` is frozen.
- `perf_fetch_cnt`  out  32: instructions accepted (see Configuration).
- `perf_stall_cnt`  out  32: stalled cycles (see Configuration).

## Operation
- Next-PC prediction (combinational, always-taken):
  - `f_icode` is 7 (jXX) or 8 (call): `pred = f_valC`.
  - Any other icode: `pred = f_valP`.
  - `ret` (9) is not predicted and uses `f_valP`; its correction comes from W.
- Redirect, decoded internally: `redirect = (M_icode==7 && !M_cnd) || (W_icode==9)`.
- Stop condition: `stop_ev = !redirect && (f_icode==0 || f_icode>4'hB || imem_error)`.
- State machine:
  - States RUN and STOP; `F_stop = (state==STOP)`.
  - RUN, on `stop_ev` with `!F_stall`: load `pred` into `F_predPC` and go to STOP.
  - STOP: `F_predPC` holds. On `redirect`, load `pred` and go to RUN; otherwise stay in STOP.
- Update priority per edge:
  1. `rst`: `F_predPC=RESET_PC`, state RUN, counters 0.
  2. `redirect`: load `pred`, state RUN. Redirect overrides `F_stall`; control must never assert both, but the block must still be deterministic when they coincide.
  3. `F_stall`: hold everything.
  4. RUN: load `pred`.
  5. STOP: hold.
- Arithmetic: the PC is a full 64-bit value with no alignment checks. `f_valP` is taken as supplied; wrap past `64'hFFFF_FFFF_FFFF_FFFF` is the producer's concern.

## Timing
- Reset values: `F_predPC=RESET_PC`, `F_stop=0`, both counters 0. Reset is sampled only on the clock edge.
- Latency: 1 cycle, inputs at edge N to `F_predPC` after edge N. There is no combinational path from any input to any output.
- Stall: `F_predPC` and state are unchanged for every cycle `F_stall=1`.
- Stop ordering: a `halt` fetched at edge N gives `F_stop=1` after edge N. `F_predPC` equals that `halt`'s `f_valP`.
- Redirect while stopped: `F_stop` drops in the cycle after the redirect edge.
- A `rst` that arrives mid-stop or mid-stall returns the block to RUN at `RESET_PC` on that edge.

## Configuration
- `FETCH_PERF_EN` defined:
  - `perf_fetch_cnt` increments on every edge where state is RUN, `!F_stall` and `!rst`.
  - `perf_stall_cnt` increments on every edge where `F_stall=1`.
  - Both counters saturate at `32'hFFFF_FFFF` and clear only on `rst`.
- `FETCH_PERF_EN` undefined: both outputs are tied to 0 and no counter flops are built. All other behaviour is identical.

## Test plan
- Reset with `RESET_PC=64'h100` for 2 cycles, then release with `f_icode=1`, `f_valP=64'h101` -> `F_predPC=0x100`, `F_stop=0` during reset; `F_predPC=0x101` one edge after release.
- Prediction: `f_icode=7`, `f_valC=0x40`, `f_valP=0x109` -> `F_predPC=0x40`. `f_icode=8`, `f_valC=0x80` -> `0x80`. `f_icode=9`, `f_valP=0x200` -> `0x200`.
- Stall: `F_predPC=0x40`, then `F_stall=1` for 3 cycles with varying `f_*` -> `F_predPC` stays 0x40. With `FETCH_PERF_EN`, `perf_stall_cnt` goes 0→3.
- Stop and redirect: `f_icode=0`, `f_valP=0x31` -> `F_stop=1`, `F_predPC=0x31`, frozen for 4 cycles. Then `M_icode=7`, `M_cnd=0`, `f_icode=1`, `f_valP=0x21` -> `F_stop=0`, `F_predPC=0x21`.
- Squashed stop: `f_icode=4'hF` in the same cycle as `W_icode=9`, `f_valP=0x55` -> `F_stop` stays 0 and `F_predPC=0x55`. `imem_error=1` with no redirect -> `F_stop=1`.
- Reset mid-stop and counter saturation:
  - In STOP, assert `rst` -> `F_predPC=RESET_PC`, `F_stop=0`.
  - Force `perf_fetch_cnt` to `32'hFFFF_FFFE`, then run 3 cycles -> counter ends at `FFFF_FFFF`.
